axi_burst_slave_ram: RTL and testbench
======================================

// Module: axi_burst_slave_ram
// PURPOSE
// AXI4 memory-mapped slave backed by byte-addressed RAM (2**ADDRESS_WIDTH bytes). Services full read
// and write bursts (FIXED/INCR/WRAP, narrow sizes, byte strobes, IDs) on independent channels.
// Used as the reference target for AXI master testing in this design.
// PARAMETERS
// DATA_WIDTH     32                data bus width; power of 2, >= 8
// STROBE_WIDTH   DATA_WIDTH/8      byte lanes per beat
// ADDRESS_WIDTH  8                 byte address width; RAM depth = 2**ADDRESS_WIDTH bytes
// ID_WIDTH       4                 width of awid/bid/arid/rid
// PORTS
// aclk     in   1     clock; all logic on posedge
// aresetn  in   1     reset, synchronous, active-low
// awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDRESS_WIDTH/8/3/2   write address
// awvalid in 1; awready out 1          write address handshake
// wdata in DATA_WIDTH; wstrb in STROBE_WIDTH; wlast in 1; wvalid in 1; wready out 1   write data
// bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1     write response
// arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDRESS_WIDTH/8/3/2   read address
// arvalid in 1; arready out 1          read address handshake
// rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1
// BEHAVIOUR
// - Reset (aresetn=0 at posedge): both FSMs -> IDLE; awready=arready=1, wready=bvalid=rvalid=rlast=0,
//   bresp=rresp=0, bid=rid=0, rdata=0. RAM contents NOT cleared. Reset mid-burst abandons the burst.
// - Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE; AW handshake latches
//   id/addr/len/size/burst, beat count=0. wready=1 only in W_DATA; each W handshake writes byte lanes
//   k with wstrb[k]=1 inside active window [addr%STROBE_WIDTH aligned to 2**size, +2**size) to
//   ram[(addr & ~(STROBE_WIDTH-1)) + k]. After beat len (len+1 beats total) -> W_RESP next cycle.
//   bvalid=1 in W_RESP, held until bready; then W_IDLE (awready=1 the following cycle).
// - Read FSM R_IDLE -> R_DATA -> R_IDLE. arready=1 only in R_IDLE. First beat valid 1 cycle after AR
//   handshake. rdata = full aligned word ram[(addr & ~(STROBE_WIDTH-1)) + k], registered; rdata/rresp/
//   rlast/rid stable while rvalid & !rready. Next beat presented cycle after handshake (no bubble
//   once rready held). rlast=1 on beat len only. After last handshake -> R_IDLE, arready=1 next cycle.
// - Address sequencing (per beat, after handshake): FIXED: unchanged. INCR: aligned(addr,size)+2**size,
//   mod 2**ADDRESS_WIDTH (wraps at top of RAM). WRAP: boundary = (len+1)*2**size; addr increments and
//   wraps to the boundary-aligned base; WRAP requires len in {1,3,7,15}.
// - Errors (resp 2'b10 SLVERR, else OKAY 2'b00): size > log2(STROBE_WIDTH); burst=2'b11; WRAP with
//   illegal len. Erroneous bursts: writes suppress all RAM updates but consume len+1 beats; reads
//   return rdata=0 for len+1 beats. Write: wlast mismatch (wlast=1 before beat len, or 0 on beat len)
//   -> bresp SLVERR; data beats still written; burst still ends after len+1 beats.
// - Simultaneous read and write of same byte in same cycle: read returns old value.
// - Read and write channels fully independent; no ordering between them.
// STRUCTURE
// - Package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, FSM state localparams, burst-legality
//   function.
// - Sub-module axi_burst_addr_gen (instantiated twice, one per channel): holds addr/len/size/burst,
//   beat count; outputs cur_addr, lane window, last_beat, err; advances on 'step'.
// - RAM: reg [7:0] ram [0:2**ADDRESS_WIDTH-1], per-byte write enable.
// TESTING (DATA_WIDTH=32, ADDRESS_WIDTH=8)
// 1 INCR write awaddr=0x10,len=3,size=2, wdata 0xA0..A3, wstrb=F; read same -> rdata A0..A3, rlast beat 3,
//   bresp=rresp=OKAY, bid/rid echo awid=5/arid=9.
// 2 WRAP read araddr=0x18,len=3,size=2 -> addresses 0x18,0x1C,0x10,0x14 in order.
// 3 Narrow INCR write awaddr=0x21,len=2,size=0, wstrb=F -> only bytes 0x21,0x22,0x23 change.
// 4 arsize=3 -> 1+len beats rdata=0, rresp=SLVERR; awburst=3 -> RAM unchanged, bresp=SLVERR.
// 5 rready toggled 1/0 every cycle on len=7 read -> outputs stable while stalled, 8 beats, no loss;
//   wlast=1 on beat 1 of len=3 write -> bresp=SLVERR.
// 6 aresetn=0 mid read burst (beat 2) -> next cycle rvalid=0, arready=1; earlier writes still readable.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and burst legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // A burst is erroneous when its beat is wider than the bus, its type is
  // reserved, or it is a WRAP whose beat count is not 2, 4, 8 or 16.
  function automatic logic burst_err(input logic [1:0] burst,
                                     input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [2:0] max_size);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > max_size) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-channel burst tracker: current/next beat address, byte-lane window, beat count, error flag.
// Latency: loads on the address handshake; advances one beat per cycle that 'step' is high.
// Backpressure: none of its own; the owning FSM only steps on a completed data handshake.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int STROBE_WIDTH  = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          load,
  input  logic [ADDRESS_WIDTH-1:0]      addr_in,
  input  logic [7:0]                    len_in,
  input  logic [2:0]                    size_in,
  input  logic [1:0]                    burst_in,
  input  logic                          step,
  output logic [ADDRESS_WIDTH-1:0]      cur_addr,
  output logic [ADDRESS_WIDTH-1:0]      next_addr,
  output logic [$clog2(STROBE_WIDTH):0] lane_lo,
  output logic [$clog2(STROBE_WIDTH):0] lane_hi,
  output logic                          last_beat,
  output logic                          next_last,
  output logic                          err
);

  localparam int         LANE_W   = $clog2(STROBE_WIDTH) + 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STROBE_WIDTH));

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [LANE_W-1:0]        lane_t;

  addr_t       addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        err_q;

  addr_t beat_bytes;
  addr_t aligned;
  addr_t incr_addr;
  addr_t wrap_mask;
  addr_t wrap_addr;
  lane_t lo;

  // Capture the burst descriptor on the address handshake, then walk one beat per step.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      addr_q  <= addr_in;
      len_q   <= len_in;
      cnt_q   <= '0;
      size_q  <= size_in;
      burst_q <= burst_in;
      err_q   <= burst_err(burst_in, len_in, size_in, MAX_SIZE);
    end else if (step) begin
      addr_q  <= next_addr;
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  // Next-beat address (wrapping mod RAM size) and the active lane window of the current beat.
  always_comb begin
    beat_bytes = addr_t'(1) << size_q;
    aligned    = addr_q & ~(beat_bytes - addr_t'(1));
    incr_addr  = aligned + beat_bytes;
    wrap_mask  = ((addr_t'(len_q) + addr_t'(1)) << size_q) - addr_t'(1);
    wrap_addr  = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
    case (burst_q)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = wrap_addr;
      default:    next_addr = addr_q;
    endcase
    lo      = lane_t'(aligned & addr_t'(STROBE_WIDTH - 1));
    lane_lo = lo;
    lane_hi = lo + lane_t'(beat_bytes);
  end

  assign cur_addr  = addr_q;
  assign last_beat = (cnt_q == len_q);
  assign next_last = ((cnt_q + 8'd1) == len_q);
  assign err       = err_q;

endmodule

// File: rtl/axi_burst_slave_ram.sv
// AXI4 burst slave over a byte-addressed RAM with fully independent read and write channels.
// Latency: first R beat one cycle after AR handshake, then one beat per cycle; B one cycle after last W.
// Backpressure: R outputs hold while rready is low; bvalid holds until bready; awready/arready drop per burst.
module axi_burst_slave_ram
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ID_WIDTH      = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ID_WIDTH-1:0]      awid,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [STROBE_WIDTH-1:0]  wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_WIDTH-1:0]      bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ID_WIDTH-1:0]      arid,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_WIDTH-1:0]      rid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready
);

  localparam int         LANE_W   = $clog2(STROBE_WIDTH) + 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STROBE_WIDTH));

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [LANE_W-1:0]        lane_t;

  localparam addr_t WORD_MASK = addr_t'(STROBE_WIDTH - 1);

  logic [7:0] ram [0:2**ADDRESS_WIDTH-1];

  wr_state_t w_state;
  rd_state_t r_state;
  logic      w_wlast_err;

  logic  aw_fire, w_fire, w_step, ar_fire, r_step, ar_err;
  addr_t w_cur_addr, w_next_addr, w_base;
  lane_t w_lane_lo, w_lane_hi;
  logic  w_last_beat, w_next_last, w_err;
  addr_t r_cur_addr, r_next_addr, rd_sel_addr, rd_base;
  lane_t r_lane_lo, r_lane_hi;
  logic  r_last_beat, r_next_last, r_err;
  logic [DATA_WIDTH-1:0] rd_word;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready && aresetn;
  assign w_step  = w_fire && !w_last_beat;
  assign ar_fire = arvalid && arready;
  assign r_step  = rvalid && rready && !rlast;
  assign ar_err  = burst_err(arburst, arlen, arsize, MAX_SIZE);
  assign w_base  = w_cur_addr & ~WORD_MASK;

  axi_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)) u_wr_gen (
    .aclk(aclk), .aresetn(aresetn), .load(aw_fire), .addr_in(awaddr), .len_in(awlen),
    .size_in(awsize), .burst_in(awburst), .step(w_step), .cur_addr(w_cur_addr),
    .next_addr(w_next_addr), .lane_lo(w_lane_lo), .lane_hi(w_lane_hi),
    .last_beat(w_last_beat), .next_last(w_next_last), .err(w_err)
  );

  axi_burst_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)) u_rd_gen (
    .aclk(aclk), .aresetn(aresetn), .load(ar_fire), .addr_in(araddr), .len_in(arlen),
    .size_in(arsize), .burst_in(arburst), .step(r_step), .cur_addr(r_cur_addr),
    .next_addr(r_next_addr), .lane_lo(r_lane_lo), .lane_hi(r_lane_hi),
    .last_beat(r_last_beat), .next_last(r_next_last), .err(r_err)
  );

  // The write side never looks ahead and the read side always returns whole words.
  logic unused_wr_gen, unused_rd_gen;
  assign unused_wr_gen = ^{w_next_addr, w_next_last};
  assign unused_rd_gen = ^{r_cur_addr, r_lane_lo, r_lane_hi, r_last_beat};

  // Byte-lane writes: only strobed lanes inside the beat's window, never for an erroneous burst.
  always_ff @(posedge aclk) begin
    if (w_fire && !w_err) begin
      for (int k = 0; k < STROBE_WIDTH; k++) begin
        if (wstrb[k] && (lane_t'(k) >= w_lane_lo) && (lane_t'(k) < w_lane_hi))
          ram[w_base + addr_t'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  // Word to be registered into rdata: the AR address for beat 0, the look-ahead address afterwards.
  always_comb begin
    rd_word     = '0;
    rd_sel_addr = (r_state == R_IDLE) ? araddr : r_next_addr;
    rd_base     = rd_sel_addr & ~WORD_MASK;
    for (int k = 0; k < STROBE_WIDTH; k++)
      rd_word[8*k +: 8] = ram[rd_base + addr_t'(k)];
  end

  // Write channel FSM: accept AW, absorb len+1 beats, then hold B until accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state     <= W_IDLE;
      awready     <= 1'b1;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
      bid         <= '0;
      w_wlast_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            awready     <= 1'b0;
            wready      <= 1'b1;
            bid         <= awid;
            w_wlast_err <= 1'b0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (wlast != w_last_beat)
              w_wlast_err <= 1'b1;
            if (w_last_beat) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_wlast_err || !wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: register each beat so outputs stay frozen while the master stalls.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            rdata   <= ar_err ? '0 : rd_word;
            rlast   <= (arlen == 8'd0);
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata <= r_err ? '0 : rd_word;
              rlast <= r_next_last;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_slave_ram.sv
// Directed bench for axi_burst_slave_ram (32-bit data, 8-bit address).
// Inputs driven on negedge, outputs sampled on negedge.
// Each task checks its own scenario against hand-computed values.
module tb_axi_burst_slave_ram;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid;
  logic [7:0]  awaddr, awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [7:0]  araddr, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf  [16];
  logic [3:0]  sbuf  [16];
  logic        lbuf  [16];
  logic [31:0] rbuf  [16];
  logic        rlbuf [16];
  logic [1:0]  rrbuf [16];
  logic [3:0]  ridbuf[16];
  int          rbeats;
  logic [1:0]  bresp_got;
  logic [3:0]  bid_got;

  always #5 aclk = ~aclk;

  axi_burst_slave_ram #(.DATA_WIDTH(32), .STROBE_WIDTH(4), .ADDRESS_WIDTH(8), .ID_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = lbuf[i]; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge aclk); t++; end
      if (t >= 50) begin checks++; errors++; $display("FAIL w_timeout beat %0d: wready=%b required 1", i, wready); end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge aclk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
    bresp_got = bresp; bid_got = bid;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int t;
    bit ph, stalled;
    logic [31:0] st_data;
    logic        st_last;
    logic [1:0]  st_resp;
    logic [3:0]  st_id;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
    @(negedge aclk);
    arvalid = 1'b0;
    rbeats = 0; t = 0; ph = 1'b0; stalled = 1'b0;
    st_data = '0; st_last = 1'b0; st_resp = '0; st_id = '0;
    while (rbeats < int'(len) + 1 && t < 400) begin
      if (toggle) begin rready = ph; ph = ~ph; end else rready = 1'b1;
      if (rvalid) begin
        if (stalled) begin
          checks++;
          if (rdata !== st_data || rlast !== st_last || rresp !== st_resp || rid !== st_id) begin
            errors++;
            $display("FAIL stall_hold beat %0d: got %h/%b/%b/%h required %h/%b/%b/%h",
                     rbeats, rdata, rlast, rresp, rid, st_data, st_last, st_resp, st_id);
          end
        end
        if (rready) begin
          rbuf[rbeats] = rdata; rlbuf[rbeats] = rlast; rrbuf[rbeats] = rresp; ridbuf[rbeats] = rid;
          rbeats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          st_data = rdata; st_last = rlast; st_resp = rresp; st_id = rid;
        end
      end
      @(negedge aclk);
      t++;
    end
    if (t >= 400) begin checks++; errors++; $display("FAIL r_timeout: beats=%0d required %0d", rbeats, int'(len) + 1); end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (awready !== 1'b1 || arready !== 1'b1) begin errors++; $display("FAIL reset_ready: awready=%b arready=%b required 1/1", awready, arready); end
    checks++; if (wready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL reset_wr: wready=%b bvalid=%b required 0/0", wready, bvalid); end
    checks++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin errors++; $display("FAIL reset_rd: rvalid=%b rlast=%b required 0/0", rvalid, rlast); end
    checks++; if (bresp !== 2'b00 || rresp !== 2'b00 || bid !== 4'd0 || rid !== 4'd0 || rdata !== 32'd0) begin
      errors++; $display("FAIL reset_vals: bresp=%b rresp=%b bid=%h rid=%h rdata=%h required zeros", bresp, rresp, bid, rid, rdata);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_incr();
    logic [31:0] exp [4];
    exp[0] = 32'h000000A0; exp[1] = 32'h000000A1; exp[2] = 32'h000000A2; exp[3] = 32'h000000A3;
    for (int i = 0; i < 4; i++) begin wbuf[i] = exp[i]; sbuf[i] = 4'hF; lbuf[i] = (i == 3); end
    do_write(4'd5, 8'h10, 8'd3, 3'd2, 2'b01);
    checks++; if (bresp_got !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", bresp_got); end
    checks++; if (bid_got !== 4'd5) begin errors++; $display("FAIL incr_bid: got %h required 5", bid_got); end
    do_read(4'd9, 8'h10, 8'd3, 3'd2, 2'b01, 1'b0);
    checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL incr_rd_idle: arready=%b rvalid=%b required 1/0", arready, rvalid); end
    checks++; if (rbeats !== 4) begin errors++; $display("FAIL incr_beats: got %0d required 4", rbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp[i] || rlbuf[i] !== (i == 3) || rrbuf[i] !== 2'b00 || ridbuf[i] !== 4'd9) begin
        errors++;
        $display("FAIL incr_beat%0d: got %h last=%b resp=%b id=%h required %h last=%b resp=00 id=9",
                 i, rbuf[i], rlbuf[i], rrbuf[i], ridbuf[i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [4];
    exp[0] = 32'h000000A2; exp[1] = 32'h000000A3; exp[2] = 32'h000000A0; exp[3] = 32'h000000A1;
    do_read(4'd2, 8'h18, 8'd3, 3'd2, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp[i] || rlbuf[i] !== (i == 3) || rrbuf[i] !== 2'b00) begin
        errors++;
        $display("FAIL wrap_beat%0d: got %h last=%b resp=%b required %h last=%b resp=00",
                 i, rbuf[i], rlbuf[i], rrbuf[i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_narrow();
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788;
    sbuf[0] = 4'hF; sbuf[1] = 4'hF; lbuf[0] = 1'b0; lbuf[1] = 1'b1;
    do_write(4'd1, 8'h20, 8'd1, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'hDDCCBBAA; sbuf[i] = 4'hF; lbuf[i] = (i == 2); end
    do_write(4'd1, 8'h21, 8'd2, 3'd0, 2'b01);
    checks++; if (bresp_got !== 2'b00) begin errors++; $display("FAIL narrow_bresp: got %b required 00", bresp_got); end
    do_read(4'd1, 8'h20, 8'd1, 3'd2, 2'b01, 1'b0);
    checks++; if (rbuf[0] !== 32'hDDCCBB44) begin errors++; $display("FAIL narrow_word20: got %h required ddccbb44", rbuf[0]); end
    checks++; if (rbuf[1] !== 32'h55667788) begin errors++; $display("FAIL narrow_word24: got %h required 55667788", rbuf[1]); end
  endtask

  task automatic test_errors();
    do_read(4'd4, 8'h10, 8'd1, 3'd3, 2'b01, 1'b0);
    checks++; if (rbeats !== 2) begin errors++; $display("FAIL size_err_beats: got %0d required 2", rbeats); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rbuf[i] !== 32'd0 || rrbuf[i] !== 2'b10) begin
        errors++; $display("FAIL size_err_beat%0d: got %h resp=%b required 00000000 resp=10", i, rbuf[i], rrbuf[i]);
      end
    end
    do_read(4'd4, 8'h10, 8'd2, 3'd2, 2'b10, 1'b0);
    checks++; if (rbeats !== 3 || rbuf[2] !== 32'd0 || rrbuf[0] !== 2'b10 || rlbuf[2] !== 1'b1) begin
      errors++; $display("FAIL wrap_len_err: beats=%0d data=%h resp=%b last=%b required 3/0/10/1", rbeats, rbuf[2], rrbuf[0], rlbuf[2]);
    end
    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'hDEADBEEF;
    sbuf[0] = 4'hF; sbuf[1] = 4'hF; lbuf[0] = 1'b0; lbuf[1] = 1'b1;
    do_write(4'd6, 8'h10, 8'd1, 3'd2, 2'b11);
    checks++; if (bresp_got !== 2'b10) begin errors++; $display("FAIL burst_err_bresp: got %b required 10", bresp_got); end
    do_read(4'd4, 8'h10, 8'd1, 3'd2, 2'b01, 1'b0);
    checks++; if (rbuf[0] !== 32'h000000A0 || rbuf[1] !== 32'h000000A1) begin
      errors++; $display("FAIL burst_err_ram: got %h %h required 000000a0 000000a1", rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [8];
    wbuf[0] = 32'hCAFE0028; wbuf[1] = 32'hCAFE002C;
    sbuf[0] = 4'hF; sbuf[1] = 4'hF; lbuf[0] = 1'b0; lbuf[1] = 1'b1;
    do_write(4'd3, 8'h28, 8'd1, 3'd2, 2'b01);
    exp[0] = 32'h000000A0; exp[1] = 32'h000000A1; exp[2] = 32'h000000A2; exp[3] = 32'h000000A3;
    exp[4] = 32'hDDCCBB44; exp[5] = 32'h55667788; exp[6] = 32'hCAFE0028; exp[7] = 32'hCAFE002C;
    do_read(4'd7, 8'h10, 8'd7, 3'd2, 2'b01, 1'b1);
    checks++; if (rbeats !== 8) begin errors++; $display("FAIL bp_beats: got %0d required 8", rbeats); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rbuf[i] !== exp[i] || rlbuf[i] !== (i == 7) || ridbuf[i] !== 4'd7) begin
        errors++; $display("FAIL bp_beat%0d: got %h last=%b id=%h required %h last=%b id=7",
                           i, rbuf[i], rlbuf[i], ridbuf[i], exp[i], (i == 7));
      end
    end
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h30 + i; sbuf[i] = 4'hF; lbuf[i] = (i == 1) || (i == 3); end
    do_write(4'd8, 8'h30, 8'd3, 3'd2, 2'b01);
    checks++; if (bresp_got !== 2'b10 || bid_got !== 4'd8) begin
      errors++; $display("FAIL wlast_err_bresp: got %b id=%h required 10 id=8", bresp_got, bid_got);
    end
    do_read(4'd8, 8'h30, 8'd3, 3'd2, 2'b01, 1'b0);
    checks++; if (rbuf[0] !== 32'h30 || rbuf[1] !== 32'h31 || rbuf[2] !== 32'h32 || rbuf[3] !== 32'h33) begin
      errors++; $display("FAIL wlast_err_data: got %h %h %h %h required 30 31 32 33", rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    int n;
    arid = 4'd3; araddr = 8'h10; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1; n = 0; t = 0;
    while (n < 2 && t < 50) begin
      if (rvalid) n++;
      @(negedge aclk);
      t++;
    end
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h000000A2) begin
      errors++; $display("FAIL mid_burst_beat2: rvalid=%b rdata=%h required 1 000000a2", rvalid, rdata);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0 || rdata !== 32'd0) begin
      errors++; $display("FAIL mid_burst_reset: rvalid=%b arready=%b rlast=%b rdata=%h required 0/1/0/0", rvalid, arready, rlast, rdata);
    end
    aresetn = 1'b1;
    rready = 1'b0;
    @(negedge aclk);
    do_read(4'd2, 8'h10, 8'd4, 3'd2, 2'b01, 1'b0);
    checks++; if (rbuf[0] !== 32'h000000A0 || rbuf[3] !== 32'h000000A3 || rbuf[4] !== 32'hDDCCBB44 || rlbuf[4] !== 1'b1) begin
      errors++; $display("FAIL post_reset_ram: got %h %h %h last=%b required 000000a0 000000a3 ddccbb44 last=1",
                         rbuf[0], rbuf[3], rbuf[4], rlbuf[4]);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    @(negedge aclk);
    test_reset();
    test_incr();
    test_wrap();
    test_narrow();
    test_errors();
    test_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
